// File: rtl/snake_pkg.sv
// Shared types and constants for the grid snake: directions, FSM states,
// grid points, colours and reset positions.
package snake_pkg;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RELOC = 2'd2,
        DEAD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
    } point_t;

    localparam logic [11:0] COL_OFF     = 12'h000;
    localparam logic [11:0] COL_HEAD    = 12'hF00;
    localparam logic [11:0] COL_BODY    = 12'h0F0;
    localparam logic [11:0] COL_APPLE   = 12'hF80;
    localparam logic [11:0] COL_BG_RUN  = 12'h0FF;
    localparam logic [11:0] COL_BG_DEAD = 12'hF00;

    localparam logic [6:0]  START_X   = 7'd40;
    localparam logic [5:0]  START_Y   = 6'd30;
    localparam logic [6:0]  APPLE_X   = 7'd60;
    localparam logic [5:0]  APPLE_Y   = 6'd30;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // RIGHT/LEFT and UP/DOWN differ only in bit 0.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11), seeded on rst;
// presents its bits as a candidate grid point for apple placement.
module snake_lfsr
    import snake_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    output point_t cand
);

    logic [15:0] value;
    logic        feedback;

    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

    assign cand = '{x: value[6:0], y: value[13:8]};

endmodule

// File: rtl/snake_controller.sv
// Grid snake game: multi-segment body, apple growth, self/wall collision, score
// and VGA cell rendering. Define SNAKE_WRAP_EN to wrap the head around the grid.
module snake_controller
    import snake_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int INIT_LEN   = 3,
    parameter int CELL_SHIFT = 3,
    parameter int GRID_W     = 80,
    parameter int GRID_H     = 60,
    parameter int MOVE_DIV   = 2_000_000,
    parameter int H_ORG      = 144,
    parameter int V_ORG      = 35
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    output logic [11:0] rgb,
    output logic [11:0] background,
    output logic [7:0]  score,
    output logic        game_over
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [6:0] X_MAX = 7'(GRID_W - 1);
    localparam logic [5:0] Y_MAX = 6'(GRID_H - 1);
    localparam logic [9:0] H0 = 10'(H_ORG);
    localparam logic [9:0] V0 = 10'(V_ORG);
`ifdef SNAKE_WRAP_EN
    localparam bit WALLS = 1'b0;
`else
    localparam bit WALLS = 1'b1;
`endif

    state_t           state;
    dir_t             dir;
    dir_t             next_dir;
    point_t           seg [MAX_LEN];
    point_t           apple;
    logic [LEN_W-1:0] length;
    logic [CNT_W-1:0] cnt;

    point_t cand;
    logic   tick;
    logic   req_valid;
    dir_t   req_dir;
    dir_t   dir_after;
    point_t new_head;
    logic   edge_hit;
    logic   self_hit;
    logic   crash;
    logic   eat;

    snake_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .cand (cand)
    );

    assign tick = (state == RUN) && (cnt == CNT_W'(MOVE_DIV - 1));

    always_comb begin
        req_valid = right | left | up | down;
        req_dir   = RIGHT;
        if (right)     req_dir = RIGHT;
        else if (left) req_dir = LEFT;
        else if (up)   req_dir = UP;
        else if (down) req_dir = DOWN;
    end

    // Reversal is judged against the direction in force after this edge.
    assign dir_after = tick ? next_dir : dir;

    always_comb begin
        new_head = seg[0];
        edge_hit = 1'b0;
        case (next_dir)
            RIGHT: begin
                if (seg[0].x == X_MAX) begin
                    new_head.x = 7'd0;
                    edge_hit   = 1'b1;
                end else begin
                    new_head.x = seg[0].x + 7'd1;
                end
            end
            LEFT: begin
                if (seg[0].x == 7'd0) begin
                    new_head.x = X_MAX;
                    edge_hit   = 1'b1;
                end else begin
                    new_head.x = seg[0].x - 7'd1;
                end
            end
            UP: begin
                if (seg[0].y == 6'd0) begin
                    new_head.y = Y_MAX;
                    edge_hit   = 1'b1;
                end else begin
                    new_head.y = seg[0].y - 6'd1;
                end
            end
            DOWN: begin
                if (seg[0].y == Y_MAX) begin
                    new_head.y = 6'd0;
                    edge_hit   = 1'b1;
                end else begin
                    new_head.y = seg[0].y + 6'd1;
                end
            end
            default: ;
        endcase
    end

    // The tail cell is excluded: it vacates on the same move.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN - 1; i++) begin
            if (i < int'(length) - 1 && seg[i] == new_head) self_hit = 1'b1;
        end
    end

    assign crash = self_hit | (edge_hit & WALLS);
    assign eat   = (new_head == apple);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dir        <= RIGHT;
            next_dir   <= RIGHT;
            length     <= LEN_W'(INIT_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                seg[i] <= '{x: START_X - 7'(i), y: START_Y};
            end
            apple      <= '{x: APPLE_X, y: APPLE_Y};
            score      <= 8'd0;
            game_over  <= 1'b0;
            background <= COL_BG_RUN;
            cnt        <= '0;
        end else begin
            if (req_valid && req_dir != opposite(dir_after)) next_dir <= req_dir;
            case (state)
                IDLE: begin
                    if (req_valid) state <= RUN;
                end
                RUN: begin
                    if (tick) begin
                        cnt <= '0;
                        dir <= next_dir;
                        if (crash) begin
                            state      <= DEAD;
                            game_over  <= 1'b1;
                            background <= COL_BG_DEAD;
                        end else begin
                            for (int i = 1; i < MAX_LEN; i++) begin
                                seg[i] <= seg[i-1];
                            end
                            seg[0] <= new_head;
                            if (eat) begin
                                if (length != LEN_W'(MAX_LEN)) length <= length + 1'b1;
                                if (score != 8'hFF) score <= score + 8'd1;
                                state <= RELOC;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELOC: begin
                    if (int'(cand.x) < GRID_W && int'(cand.y) < GRID_H && cand != seg[0]) begin
                        apple <= cand;
                        state <= RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [9:0] rel_h;
    logic [9:0] rel_v;
    logic [9:0] cx;
    logic [9:0] cy;
    logic       on_head;
    logic       on_body;
    logic       on_apple;

    assign rel_h = hCount - H0;
    assign rel_v = vCount - V0;
    assign cx    = rel_h >> CELL_SHIFT;
    assign cy    = rel_v >> CELL_SHIFT;

    function automatic logic at_cell(input point_t p, input logic [9:0] px, input logic [9:0] py);
        return (px == {3'b000, p.x}) && (py == {4'b0000, p.y});
    endfunction

    always_comb begin
        on_head  = at_cell(seg[0], cx, cy);
        on_apple = at_cell(apple, cx, cy);
        on_body  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (i < int'(length) && at_cell(seg[i], cx, cy)) on_body = 1'b1;
        end
    end

    always_comb begin
        if (!bright)       rgb = COL_OFF;
        else if (on_head)  rgb = COL_HEAD;
        else if (on_body)  rgb = COL_BODY;
        else if (on_apple) rgb = COL_APPLE;
        else               rgb = background;
    end

endmodule

// File: tb/tb_snake_controller.sv
// Bench for snake_controller: rendering vector table, movement, turn rules,
// eating/relocation, edge behaviour, self-collision and reset during RELOC.
`timescale 1ns/1ps
module tb_snake_controller;
    import snake_pkg::*;

    localparam int MOVE_DIV = 4;

    logic        clk = 1'b0;
    logic        rst, rst5;
    logic        up, down, left, right;
    logic        up5, down5, left5, right5;
    logic        bright;
    logic [9:0]  hCount, vCount;
    logic [11:0] rgb, background, rgb5, background5;
    logic [7:0]  score, score5;
    logic        game_over, game_over5;

    always #5 clk = ~clk;

    snake_controller #(.MOVE_DIV(MOVE_DIV)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .bright(bright), .hCount(hCount), .vCount(vCount),
        .rgb(rgb), .background(background), .score(score), .game_over(game_over)
    );

    snake_controller #(.MOVE_DIV(MOVE_DIV), .INIT_LEN(5)) dut5 (
        .clk(clk), .rst(rst5), .up(up5), .down(down5), .left(left5), .right(right5),
        .bright(bright), .hCount(hCount), .vCount(vCount),
        .rgb(rgb5), .background(background5), .score(score5), .game_over(game_over5)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        b;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[9];

    function automatic logic [31:0] pt(input int x, input int y);
        logic [6:0] px;
        logic [5:0] py;
        px = 7'(x);
        py = 6'(y);
        return {19'd0, px, py};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_next(input string name, input logic [31:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h with no expected value queued", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    // Drive {right,left,up,down} and return #1 after the next move tick edge.
    task automatic step(input bit aux, input logic [3:0] btn);
        bit seen;
        seen = 1'b0;
        if (aux) {right5, left5, up5, down5} = btn;
        else     {right, left, up, down} = btn;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (aux ? dut5.tick : dut.tick) seen = 1'b1;
        end
        if (seen) begin
            @(posedge clk);
            #1;
        end else begin
            check("tick_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic reset_main();
        rst = 1'b1;
        {right, left, up, down} = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rst5 = 1'b1;
        {right, left, up, down} = 4'b0000;
        {right5, left5, up5, down5} = 4'b0000;
        bright = 1'b0; hCount = '0; vCount = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst5 = 1'b0;

        check("reset_state", 32'(dut.state), 32'(IDLE));
        check("reset_length", 32'(dut.length), 32'd3);
        check("reset_score", 32'(score), 32'd0);
        check("reset_game_over", 32'(game_over), 32'd0);
        check("reset_background", 32'(background), 32'h0FF);
        check("reset_head", 32'(dut.seg[0]), pt(40, 30));
        check("reset_seg2", 32'(dut.seg[2]), pt(38, 30));
        check("reset_apple", 32'(dut.apple), pt(60, 30));

        vecs[0] = '{h: 10'd464, v: 10'd275, b: 1'b1, exp: 12'hF00};
        vecs[1] = '{h: 10'd471, v: 10'd282, b: 1'b1, exp: 12'hF00};
        vecs[2] = '{h: 10'd456, v: 10'd275, b: 1'b1, exp: 12'h0F0};
        vecs[3] = '{h: 10'd448, v: 10'd275, b: 1'b1, exp: 12'h0F0};
        vecs[4] = '{h: 10'd440, v: 10'd275, b: 1'b1, exp: 12'h0FF};
        vecs[5] = '{h: 10'd624, v: 10'd275, b: 1'b1, exp: 12'hF80};
        vecs[6] = '{h: 10'd472, v: 10'd275, b: 1'b1, exp: 12'h0FF};
        vecs[7] = '{h: 10'd464, v: 10'd275, b: 1'b0, exp: 12'h000};
        vecs[8] = '{h: 10'd464, v: 10'd283, b: 1'b1, exp: 12'h0FF};
        for (int i = 0; i < 9; i++) begin
            hCount = vecs[i].h; vCount = vecs[i].v; bright = vecs[i].b;
            exp_q.push_back(32'(vecs[i].exp));
            #1;
            check_next($sformatf("render%0d", i), 32'(rgb));
        end
        for (int i = 0; i < 4; i++) begin
            hCount = 10'($urandom_range(0, 1023));
            vCount = 10'($urandom_range(0, 1023));
            bright = 1'b0;
            exp_q.push_back(32'h000);
            #1;
            check_next($sformatf("render_dark%0d", i), 32'(rgb));
        end

        step(1'b0, 4'b1000);
        check("move1_head", 32'(dut.seg[0]), pt(41, 30));
        check("move1_seg2", 32'(dut.seg[2]), pt(39, 30));
        check("move1_length", 32'(dut.length), 32'd3);
        check("move1_score", 32'(score), 32'd0);

        step(1'b0, 4'b0100);
        check("reverse_ignored", 32'(dut.seg[0]), pt(42, 30));

        {right, left, up, down} = 4'b0010;
        @(posedge clk);
        #1;
        step(1'b0, 4'b0100);
        check("turn_up_head", 32'(dut.seg[0]), pt(42, 29));
        check("turn_up_dir", 32'(dut.dir), 32'(UP));

        step(1'b0, 4'b1000);
        step(1'b0, 4'b0001);
        step(1'b0, 4'b1000);
        check("back_on_row", 32'(dut.seg[0]), pt(44, 30));

        for (int i = 0; i < 30 && dut.seg[0].x != 7'd60; i++) step(1'b0, 4'b1000);
        check("eat_head", 32'(dut.seg[0]), pt(60, 30));
        check("eat_score", 32'(score), 32'd1);
        check("eat_length", 32'(dut.length), 32'd4);
        check("eat_reloc", 32'(dut.state), 32'(RELOC));
        for (int c = 0; c < 64 && dut.state == RELOC; c++) begin
            @(posedge clk);
            #1;
        end
        check("reloc_done", 32'(dut.state), 32'(RUN));
        check("apple_x_in_grid", 32'(dut.apple.x < 7'd80), 32'd1);
        check("apple_y_in_grid", 32'(dut.apple.y < 6'd60), 32'd1);
        check("apple_off_head", 32'(dut.apple != dut.seg[0]), 32'd1);

        for (int i = 0; i < 40 && dut.seg[0].x != 7'd79; i++) step(1'b0, 4'b1000);
        check("reach_edge", 32'(dut.seg[0]), pt(79, 30));
        step(1'b0, 4'b1000);
`ifdef SNAKE_WRAP_EN
        check("wrap_head", 32'(dut.seg[0]), pt(0, 30));
        check("wrap_alive", 32'(game_over), 32'd0);
`else
        check("wall_game_over", 32'(game_over), 32'd1);
        check("wall_background", 32'(background), 32'hF00);
        check("wall_state", 32'(dut.state), 32'(DEAD));
        check("wall_head_kept", 32'(dut.seg[0]), pt(79, 30));
`endif

        reset_main();
        for (int i = 0; i < 30 && dut.state != RELOC; i++) step(1'b0, 4'b1000);
        check("enter_reloc", 32'(dut.state), 32'(RELOC));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_reloc_state", 32'(dut.state), 32'(IDLE));
        check("rst_reloc_apple", 32'(dut.apple), pt(60, 30));
        check("rst_reloc_length", 32'(dut.length), 32'd3);
        check("rst_reloc_score", 32'(score), 32'd0);
        hCount = 10'd464; vCount = 10'd275; bright = 1'b1;
        exp_q.push_back(32'hF00);
        #1;
        check_next("rst_reloc_pixel", 32'(rgb));
        rst = 1'b0;
        {right, left, up, down} = 4'b0000;

        rst5 = 1'b1;
        @(posedge clk);
        #1;
        rst5 = 1'b0;
        step(1'b1, 4'b1000);
        check("len5_first_move", 32'(dut5.seg[0]), pt(41, 30));
        check("len5_length", 32'(dut5.length), 32'd5);
        step(1'b1, 4'b0001);
        step(1'b1, 4'b0100);
        check("len5_before_up", 32'(dut5.seg[0]), pt(40, 31));
        step(1'b1, 4'b0010);
        check("self_hit_game_over", 32'(game_over5), 32'd1);
        check("self_hit_background", 32'(background5), 32'hF00);
        check("self_hit_state", 32'(dut5.state), 32'(DEAD));
        check("self_hit_no_shift", 32'(dut5.seg[0]), pt(40, 31));
        repeat (10 * MOVE_DIV) @(posedge clk);
        #1;
        check("dead_frozen_head", 32'(dut5.seg[0]), pt(40, 31));
        check("dead_frozen_seg4", 32'(dut5.seg[4]), pt(39, 30));
        check("dead_still_over", 32'(game_over5), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
